// File: rtl/mdr_store_merge_pkg.sv
// Shared size/state encodings for the MDR store-merge path.
package mdr_store_merge_pkg;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_WORD = 2'b10,
    SZ_RSVD = 2'b11
  } size_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_READ,
    ST_WRITE,
    ST_DONE
  } state_e;

  // Reserved size or an address not aligned to the access size.
  function automatic logic store_err(input size_e size, input logic [1:0] lane);
    case (size)
      SZ_BYTE: return 1'b0;
      SZ_HALF: return lane[0];
      SZ_WORD: return lane != 2'b00;
      default: return 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/mdr_store_merge_lane.sv
// Combinational lane insert: replaces the addressed byte/half of old_word, keeps the rest.
module store_lane_merge
  import mdr_store_merge_pkg::*;
(
  input  logic  [31:0] old_word_i,
  input  logic  [31:0] data_i,
  input  size_e        size_i,
  input  logic  [1:0]  lane_i,
  output logic  [31:0] new_word_o
);

  always_comb begin
    new_word_o = old_word_i;
    case (size_i)
      SZ_BYTE: new_word_o[{lane_i, 3'b000} +: 8] = data_i[7:0];
      SZ_HALF: begin
        if (lane_i[1]) new_word_o[31:16] = data_i[15:0];
        else           new_word_o[15:0]  = data_i[15:0];
      end
      SZ_WORD: new_word_o = data_i;
      default: new_word_o = old_word_i;
    endcase
  end

endmodule

// File: rtl/mdr_store_merge.sv
// Store path to word-wide memory without byte enables: sub-word stores run read-modify-write.
module mdr_store_merge
  import mdr_store_merge_pkg::*;
#(
  parameter int unsigned ADDR_W      = 32,
  parameter int unsigned ACK_TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_data,
  input  logic [1:0]        req_size,
  output logic              ready,
  output logic              done,
  output logic              err,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rd,
  output logic              mem_wr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata,
  input  logic              mem_ack
);

  localparam int unsigned CNT_W   = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(ACK_TIMEOUT - 1);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       data_q, data_d;
  size_e             size_q, size_d;
  logic [1:0]        lane_q, lane_d;
  logic [31:0]       wdata_q, wdata_d;
  logic              err_q, err_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  logic [31:0] merged;
  logic        timeout_hit;
  size_e       req_sz;

  store_lane_merge u_merge (
    .old_word_i (mem_rdata),
    .data_i     (data_q),
    .size_i     (size_q),
    .lane_i     (lane_q),
    .new_word_o (merged)
  );

  assign req_sz = size_e'(req_size);
  // Fires on the last strobe cycle allowed without ack; an ack in that cycle still wins.
  assign timeout_hit = (ACK_TIMEOUT != 0) && (cnt_q == TO_LAST);

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    data_d  = data_q;
    size_d  = size_q;
    lane_d  = lane_q;
    wdata_d = wdata_q;
    err_d   = err_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (req) begin
          addr_d = {req_addr[ADDR_W-1:2], 2'b00};
          data_d = req_data;
          size_d = req_sz;
          lane_d = req_addr[1:0];
          cnt_d  = '0;
          err_d  = 1'b0;
          if (store_err(req_sz, req_addr[1:0])) begin
            err_d   = 1'b1;
            state_d = ST_DONE;
          end else if (req_sz == SZ_WORD) begin
            wdata_d = req_data;
            state_d = ST_WRITE;
          end else begin
            state_d = ST_READ;
          end
        end
      end
      ST_READ: begin
        if (mem_ack) begin
          wdata_d = merged;
          cnt_d   = '0;
          state_d = ST_WRITE;
        end else if (timeout_hit) begin
          err_d   = 1'b1;
          state_d = ST_DONE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_WRITE: begin
        if (mem_ack) begin
          state_d = ST_DONE;
        end else if (timeout_hit) begin
          err_d   = 1'b1;
          state_d = ST_DONE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      addr_q  <= '0;
      data_q  <= '0;
      size_q  <= SZ_BYTE;
      lane_q  <= '0;
      wdata_q <= '0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      size_q  <= size_d;
      lane_q  <= lane_d;
      wdata_q <= wdata_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end

  // Strobes decode straight from the state register so an async reset drops them at once.
  assign ready     = (state_q == ST_IDLE);
  assign done      = (state_q == ST_DONE);
  assign err       = (state_q == ST_DONE) && err_q;
  assign mem_rd    = (state_q == ST_READ);
  assign mem_wr    = (state_q == ST_WRITE);
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;

endmodule

// File: tb/tb_mdr_store_merge.sv
// Scoreboard bench for mdr_store_merge: stimulus queues expected memory/done events, a monitor checks them.
module tb_mdr_store_merge;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req;
  logic [31:0] req_addr;
  logic [31:0] req_data;
  logic [1:0]  req_size;
  logic        ready, done, err, mem_rd, mem_wr, mem_ack;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;

  always #5 clk = ~clk;

  mdr_store_merge #(.ADDR_W(32), .ACK_TIMEOUT(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .req_addr  (req_addr),
    .req_data  (req_data),
    .req_size  (req_size),
    .ready     (ready),
    .done      (done),
    .err       (err),
    .mem_addr  (mem_addr),
    .mem_rd    (mem_rd),
    .mem_wr    (mem_wr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .mem_ack   (mem_ack)
  );

  // Memory responder: acks after a programmable number of wait cycles per access.
  logic [31:0] rd_word;
  bit          rd_en, wr_en;
  int          rd_dly, wr_dly, wcnt, cyc;

  assign mem_rdata = rd_word;
  assign mem_ack   = (mem_rd && rd_en && wcnt == rd_dly) || (mem_wr && wr_en && wcnt == wr_dly);

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if ((mem_rd || mem_wr) && !mem_ack) wcnt <= wcnt + 1;
    else                                wcnt <= 0;
  end

  localparam int K_RD = 0, K_WR = 1, K_DONE = 2;
  typedef struct {
    int          kind;
    logic [31:0] addr;
    logic [31:0] data;
    logic        err;
    int          cyc;
  } exp_t;

  exp_t sbq[$];
  int   nvec = 0, nmis = 0;

  task automatic check_evt(input int kind, input logic [31:0] a, input logic [31:0] d, input logic e);
    exp_t x;
    nvec++;
    if (sbq.size() == 0) begin
      nmis++;
      $display("FAIL unexpected_event kind=%0d addr=%h data=%h err=%b cyc=%0d required none", kind, a, d, e, cyc);
      return;
    end
    x = sbq.pop_front();
    if (x.kind != kind || x.addr != a || x.data != d || x.err != e || (kind == K_DONE && x.cyc != cyc)) begin
      nmis++;
      $display("FAIL event got kind=%0d addr=%h data=%h err=%b cyc=%0d required kind=%0d addr=%h data=%h err=%b cyc=%0d",
               kind, a, d, e, cyc, x.kind, x.addr, x.data, x.err, (kind == K_DONE) ? x.cyc : cyc);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      if (mem_rd && mem_wr) begin
        nmis++;
        $display("FAIL strobe_overlap mem_rd=1 mem_wr=1 required at most one");
      end
      if (mem_rd && mem_ack) check_evt(K_RD, mem_addr, 32'h0, 1'b0);
      if (mem_wr && mem_ack) check_evt(K_WR, mem_addr, mem_wdata, 1'b0);
      if (done) begin
        check_evt(K_DONE, 32'h0, 32'h0, err);
        if (ready || mem_rd || mem_wr) begin
          nmis++;
          $display("FAIL done_outputs ready=%b rd=%b wr=%b required 0 0 0", ready, mem_rd, mem_wr);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nmis++;
      $display("FAIL %s got %h required %h", name, act, exp);
    end
  endtask

  task automatic store(input logic [31:0] a, input logic [31:0] d, input logic [1:0] sz,
                       input logic [31:0] rdw, input bit exp_rd, input bit exp_wr,
                       input logic [31:0] maddr, input logic [31:0] wd, input logic e,
                       input int lat, input int spam, output int t0);
    exp_t x;
    for (int i = 0; i < 100 && !ready; i++) @(negedge clk);
    if (!ready) begin
      nvec++; nmis++;
      $display("FAIL ready_wait got ready=0 required 1");
    end
    rd_word  = rdw;
    req      = 1'b1;
    req_addr = a;
    req_data = d;
    req_size = sz;
    t0       = cyc;
    if (exp_rd) begin x = '{K_RD, maddr, 32'h0, 1'b0, 0}; sbq.push_back(x); end
    if (exp_wr) begin x = '{K_WR, maddr, wd, 1'b0, 0};    sbq.push_back(x); end
    x = '{K_DONE, 32'h0, 32'h0, e, t0 + lat};
    sbq.push_back(x);
    for (int i = 0; i < spam; i++) begin
      @(negedge clk);
      req_addr = $urandom; req_data = $urandom; req_size = 2'($urandom);
    end
    @(negedge clk);
    req      = 1'b0;
    req_addr = $urandom; req_data = $urandom; req_size = 2'($urandom);
  endtask

  task automatic drain();
    for (int i = 0; i < 60 && sbq.size() != 0; i++) @(negedge clk);
    nvec++;
    if (sbq.size() != 0) begin
      nmis++;
      $display("FAIL drain_timeout pending=%0d required 0", sbq.size());
      sbq.delete();
    end
  endtask

  int t0;

  initial begin
    req = 1'b0; req_addr = '0; req_data = '0; req_size = '0; rd_word = '0;
    rd_en = 1; wr_en = 1; rd_dly = 0; wr_dly = 0; wcnt = 0; cyc = 0;
    repeat (3) @(negedge clk);
    chk("rst_ready", {31'b0, ready}, 32'h1);
    chk("rst_done_err", {30'b0, done, err}, 32'h0);
    chk("rst_strobes", {30'b0, mem_rd, mem_wr}, 32'h0);
    chk("rst_mem_addr", mem_addr, 32'h0);
    chk("rst_mem_wdata", mem_wdata, 32'h0);
    rst_n = 1'b1;
    @(negedge clk);

    // Half upper lane, byte lane 1, word with req held high while busy.
    store(32'h102, 32'h0000BEEF, 2'b01, 32'h11223344, 1, 1, 32'h100, 32'hBEEF3344, 0, 3, 0, t0); drain();
    store(32'h201, 32'h000000A5, 2'b00, 32'hFFFFFFFF, 1, 1, 32'h200, 32'hFFFFA5FF, 0, 3, 0, t0); drain();
    store(32'h010, 32'hDEADBEEF, 2'b10, 32'h0,        0, 1, 32'h010, 32'hDEADBEEF, 0, 2, 2, t0); drain();

    // Misaligned half: error done in cycle 1, ready again in cycle 2.
    store(32'h003, 32'h00001234, 2'b01, 32'h0, 0, 0, 32'h0, 32'h0, 1, 1, 0, t0); drain();
    while (cyc < t0 + 2) @(negedge clk);
    chk("err_ready_next", {31'b0, ready}, 32'h1);

    // Remaining byte lanes (upper data bits must be ignored) and half lower lane.
    store(32'h300, 32'h123456C3, 2'b00, 32'h89ABCDEF, 1, 1, 32'h300, 32'h89ABCDC3, 0, 3, 0, t0); drain();
    store(32'h302, 32'h0000007E, 2'b00, 32'h89ABCDEF, 1, 1, 32'h300, 32'h897ECDEF, 0, 3, 0, t0); drain();
    store(32'h303, 32'h00000000, 2'b00, 32'h89ABCDEF, 1, 1, 32'h300, 32'h00ABCDEF, 0, 3, 0, t0); drain();
    store(32'h400, 32'hFFFF1357, 2'b01, 32'hA5A5A5A5, 1, 1, 32'h400, 32'hA5A51357, 0, 3, 0, t0); drain();

    // Error cases: misaligned word, reserved size, odd half.
    store(32'h012, 32'h0, 2'b10, 32'h0, 0, 0, 32'h0, 32'h0, 1, 1, 0, t0); drain();
    store(32'h000, 32'h0, 2'b11, 32'h0, 0, 0, 32'h0, 32'h0, 1, 1, 0, t0); drain();
    store(32'h001, 32'h0, 2'b01, 32'h0, 0, 0, 32'h0, 32'h0, 1, 1, 0, t0); drain();

    // Delayed acks; ack in the last allowed cycle still succeeds.
    rd_dly = 2; wr_dly = 2;
    store(32'h502, 32'h00000000, 2'b01, 32'hFFFFFFFF, 1, 1, 32'h500, 32'h0000FFFF, 0, 7, 0, t0); drain();
    rd_dly = 0; wr_dly = 3;
    store(32'h600, 32'hCAFEF00D, 2'b10, 32'h0, 0, 1, 32'h600, 32'hCAFEF00D, 0, 5, 0, t0); drain();
    wr_dly = 0;

    // Timeouts: read never acked, then write never acked after a good read.
    rd_en = 0;
    store(32'h040, 32'h00000011, 2'b00, 32'h0, 0, 0, 32'h0, 32'h0, 1, 5, 0, t0); drain();
    rd_en = 1; wr_en = 0;
    store(32'h700, 32'h00000011, 2'b00, 32'h0, 1, 0, 32'h700, 32'h0, 1, 6, 0, t0); drain();
    wr_en = 1;

    // Reset while a write is outstanding.
    wr_dly = 3;
    store(32'h800, 32'h55AA55AA, 2'b10, 32'h0, 0, 1, 32'h800, 32'h55AA55AA, 0, 5, 0, t0);
    chk("pre_reset_wr", {31'b0, mem_wr}, 32'h1);
    #2 rst_n = 1'b0;
    #1;
    chk("reset_strobes", {30'b0, mem_rd, mem_wr}, 32'h0);
    chk("reset_ready_done", {30'b0, ready, done}, 32'h2);
    chk("reset_mem_addr", mem_addr, 32'h0);
    chk("reset_mem_wdata", mem_wdata, 32'h0);
    sbq.delete();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    wr_dly = 0;
    @(negedge clk);
    store(32'h902, 32'h00004321, 2'b01, 32'h12345678, 1, 1, 32'h900, 32'h43215678, 0, 3, 0, t0); drain();

    repeat (3) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule
